// File: rtl/seg_pkg.sv
// Shared glyph constants and controller FSM encoding for the HEX display path.
// Glyphs are active-low, bit0 = segment a ... bit6 = segment g.
package seg_pkg;

    localparam logic [6:0] GLYPH_0     = 7'h40;
    localparam logic [6:0] GLYPH_1     = 7'h79;
    localparam logic [6:0] GLYPH_2     = 7'h24;
    localparam logic [6:0] GLYPH_3     = 7'h30;
    localparam logic [6:0] GLYPH_4     = 7'h19;
    localparam logic [6:0] GLYPH_5     = 7'h12;
    localparam logic [6:0] GLYPH_6     = 7'h02;
    localparam logic [6:0] GLYPH_7     = 7'h78;
    localparam logic [6:0] GLYPH_8     = 7'h00;
    localparam logic [6:0] GLYPH_9     = 7'h10;
    localparam logic [6:0] GLYPH_A     = 7'h08;
    localparam logic [6:0] GLYPH_B     = 7'h03;
    localparam logic [6:0] GLYPH_C     = 7'h46;
    localparam logic [6:0] GLYPH_D     = 7'h21;
    localparam logic [6:0] GLYPH_E     = 7'h06;
    localparam logic [6:0] GLYPH_F     = 7'h0E;
    localparam logic [6:0] GLYPH_DASH  = 7'h3F;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        UPDATE  = 2'd2
    } state_e;

endpackage

// File: rtl/seg_glyph.sv
// Combinational nibble-to-glyph decoder, one instance per display digit.
module seg_glyph
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = GLYPH_BLANK;
        case (nibble)
            4'h0: glyph = GLYPH_0;
            4'h1: glyph = GLYPH_1;
            4'h2: glyph = GLYPH_2;
            4'h3: glyph = GLYPH_3;
            4'h4: glyph = GLYPH_4;
            4'h5: glyph = GLYPH_5;
            4'h6: glyph = GLYPH_6;
            4'h7: glyph = GLYPH_7;
            4'h8: glyph = GLYPH_8;
            4'h9: glyph = GLYPH_9;
            4'hA: glyph = GLYPH_A;
            4'hB: glyph = GLYPH_B;
            4'hC: glyph = GLYPH_C;
            4'hD: glyph = GLYPH_D;
            4'hE: glyph = GLYPH_E;
            4'hF: glyph = GLYPH_F;
        endcase
    end

endmodule

// File: rtl/seg_display_ctrl.sv
// Multi-digit 7-segment controller: hex or decimal (double-dabble) display with
// leading-zero blanking, overflow dashes and whole-display blinking.
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS    = 6,
    parameter int DATA_W    = 20,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_W-1:0]     data,
    input  logic                  mode,
    input  logic                  blank_lz,
    input  logic                  blink_en,
    output logic                  busy,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int BCD_W  = 4 * (DIGITS + 1);
    localparam int SR_W   = BCD_W + DATA_W;
    localparam int DISP_W = 7 * DIGITS;
    localparam int CNT_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    state_e              state_q, state_d;
    logic [SR_W-1:0]     sr_q, sr_d;
    logic [5:0]          iter_q, iter_d;
    logic                mode_q, mode_d;
    logic                blz_q, blz_d;
    logic                sticky_q, sticky_d;
    logic                ovf_q, ovf_d;
    logic                busy_q, busy_d;
    logic [DISP_W-1:0]   disp_q, disp_d;
    logic [DISP_W-1:0]   seg_q, seg_d;
    logic [CNT_W-1:0]    bcnt_q, bcnt_d;
    logic                phase_q, phase_d;

    logic [SR_W-1:0]     sr_adj;
    logic [SR_W-1:0]     sr_step;
    logic [3:0]          nib [DIGITS];
    logic [6:0]          glyph [DIGITS];
    logic [DIGITS-1:0]   lz;
    logic                upper_zero;
    logic                ovf_now;

    // Hex shows the low binary nibbles; decimal shows the BCD field above the binary part.
    always_comb begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
            nib[i] = mode_q ? sr_q[DATA_W + 4*i +: 4] : sr_q[4*i +: 4];
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_glyph
        seg_glyph u_glyph (
            .nibble (nib[g]),
            .glyph  (glyph[g])
        );
    end

    // One double-dabble step, including the guard nibble above the displayed digits.
    always_comb begin
        sr_adj = sr_q;
        for (int unsigned i = 0; i <= DIGITS; i++) begin
            if (sr_adj[DATA_W + 4*i +: 4] >= 4'd5) begin
                sr_adj[DATA_W + 4*i +: 4] = sr_adj[DATA_W + 4*i +: 4] + 4'd3;
            end
        end
        sr_step = sr_adj << 1;
    end

    always_comb begin
        upper_zero = 1'b1;
        lz         = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            lz[DIGITS-1-k] = blz_q && upper_zero && (nib[DIGITS-1-k] == 4'd0) && (k != DIGITS-1);
            upper_zero     = upper_zero && (nib[DIGITS-1-k] == 4'd0);
        end
        ovf_now = mode_q ? sticky_q : (sr_q[SR_W-1:4*DIGITS] != '0);
    end

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        iter_d   = iter_q;
        mode_d   = mode_q;
        blz_d    = blz_q;
        sticky_d = sticky_q;
        ovf_d    = ovf_q;
        disp_d   = disp_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    mode_d   = mode;
                    blz_d    = blank_lz;
                    sr_d     = SR_W'(data);
                    sticky_d = 1'b0;
                    iter_d   = '0;
                    state_d  = mode ? CONVERT : UPDATE;
                end
            end
            CONVERT: begin
                sr_d     = sr_step;
                // Any digit reaching the guard nibble means value >= 10^DIGITS; sticky so later carries out are not missed.
                sticky_d = sticky_q | (sr_step[SR_W-1 -: 4] != 4'd0);
                iter_d   = iter_q + 6'd1;
                if (iter_q == 6'(DATA_W - 1)) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                ovf_d = ovf_now;
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    if (ovf_now) begin
                        disp_d[7*i +: 7] = GLYPH_DASH;
                    end else if (lz[i]) begin
                        disp_d[7*i +: 7] = GLYPH_BLANK;
                    end else begin
                        disp_d[7*i +: 7] = glyph[i];
                    end
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_comb begin
        if (bcnt_q == CNT_W'(BLINK_DIV - 1)) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end else begin
            bcnt_d  = bcnt_q + 1'b1;
            phase_d = phase_q;
        end
        seg_d = (blink_en && phase_q) ? '1 : disp_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            iter_q   <= '0;
            mode_q   <= 1'b0;
            blz_q    <= 1'b0;
            sticky_q <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            disp_q   <= '1;
            seg_q    <= '1;
            bcnt_q   <= '0;
            phase_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            iter_q   <= iter_d;
            mode_q   <= mode_d;
            blz_q    <= blz_d;
            sticky_q <= sticky_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            disp_q   <= disp_d;
            seg_q    <= seg_d;
            bcnt_q   <= bcnt_d;
            phase_q  <= phase_d;
        end
    end

    assign busy     = busy_q;
    assign overflow = ovf_q;
    assign seg      = seg_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Randomised bench for seg_display_ctrl against an arithmetic display model.
module tb_seg_display_ctrl;

    localparam int DIGITS    = 6;
    localparam int DATA_W    = 20;
    localparam int BLINK_DIV = 4;
    localparam int SW        = 7 * DIGITS;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load;
    logic [DATA_W-1:0] data;
    logic              mode;
    logic              blank_lz;
    logic              blink_en;
    logic              busy;
    logic              overflow;
    logic [SW-1:0]     seg;

    int n_checks = 0;
    int n_fail   = 0;
    int n_edges;

    logic [6:0] GL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [SW-1:0] cur_disp;
    bit            cur_ovf;

    always #5 clk = ~clk;

    seg_display_ctrl #(
        .DIGITS    (DIGITS),
        .DATA_W    (DATA_W),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .data     (data),
        .mode     (mode),
        .blank_lz (blank_lz),
        .blink_en (blink_en),
        .busy     (busy),
        .overflow (overflow),
        .seg      (seg)
    );

    // Edges seen since reset release; the blink phase is a pure function of this.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n_edges <= 0;
        else        n_edges <= n_edges + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic void model(input int unsigned v, input bit m, input bit blz,
                                  output logic [SW-1:0] d, output bit o);
        int unsigned     dig [DIGITS];
        longint unsigned lim;
        int unsigned     tmp;
        int              msd;
        if (m) begin
            lim = 1;
            for (int i = 0; i < DIGITS; i++) lim = lim * 10;
            o   = longint'(v) >= lim;
            tmp = v;
            for (int i = 0; i < DIGITS; i++) begin
                dig[i] = tmp % 10;
                tmp    = tmp / 10;
            end
        end else begin
            o = (DATA_W > 4*DIGITS) && ((longint'(v) >> (4*DIGITS)) != 0);
            for (int i = 0; i < DIGITS; i++) dig[i] = (v >> (4*i)) & 15;
        end
        msd = 0;
        for (int i = 0; i < DIGITS; i++) if (dig[i] != 0) msd = i;
        for (int i = 0; i < DIGITS; i++) begin
            if (o)                   d[7*i +: 7] = 7'h3F;
            else if (blz && i > msd) d[7*i +: 7] = 7'h7F;
            else                     d[7*i +: 7] = GL[dig[i]];
        end
    endfunction

    task automatic check_seg(input string tag);
        logic [SW-1:0] exp;
        if (blink_en && n_edges > 0 && (((n_edges - 1) / BLINK_DIV) % 2) == 1) exp = '1;
        else exp = cur_disp;
        check_eq(tag, seg, exp);
    endtask

    // Load at a negedge, count busy cycles, poke one load mid-busy that must be ignored.
    task automatic run_load(input int unsigned v, input bit m, input bit blz, input int unsigned ign);
        logic [SW-1:0] exp_d;
        bit            exp_o;
        int            cnt;
        int            inj;
        int            g;
        g = 0;
        while (busy && g < 200) begin
            @(negedge clk);
            g++;
        end
        check_eq("idle_before_load", busy, 0);
        data = DATA_W'(v); mode = m; blank_lz = blz; load = 1'b1;
        @(negedge clk);
        load = 1'b0; data = DATA_W'($urandom); mode = 1'($urandom); blank_lz = 1'($urandom);
        inj = m ? 3 : 1;
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            if (cnt == inj) begin
                load = 1'b1; data = DATA_W'(ign); mode = 1'($urandom);
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        check_eq("busy_cycles", cnt, m ? DATA_W + 1 : 1);
        check_seg("seg_before_latency");
        @(negedge clk);
        model(v, m, blz, exp_d, exp_o);
        cur_disp = exp_d;
        cur_ovf  = exp_o;
        check_seg("seg_value");
        check_eq("overflow", overflow, exp_o);
        check_eq("busy_after", busy, 0);
    endtask

    initial begin
        int unsigned v;
        rst_n = 1'b0; load = 1'b0; data = '0; mode = 1'b0; blank_lz = 1'b0; blink_en = 1'b0;
        cur_disp = '1; cur_ovf = 1'b0;
        #12;
        check_eq("reset_seg", seg, {SW{1'b1}});
        check_eq("reset_busy", busy, 0);
        check_eq("reset_ovf", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_load(32'hABCDE, 1'b0, 1'b0, 32'h12345);
        run_load(123456, 1'b1, 1'b0, 999);
        run_load(1048575, 1'b1, 1'b0, 5);
        run_load(0, 1'b1, 1'b1, 77);
        run_load(42, 1'b1, 1'b1, 7);
        run_load(999999, 1'b1, 1'b1, 1);
        run_load(1000000, 1'b1, 1'b0, 2);
        run_load(32'h00F00, 1'b0, 1'b1, 3);
        run_load(0, 1'b0, 1'b1, 4);

        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(0, 99);
                1:       v = $urandom & 32'hFFFFF;
                2:       v = 32'hFFFFF - $urandom_range(0, 50000);
                default: v = $urandom_range(999990, 1000010);
            endcase
            run_load(v, 1'($urandom), 1'($urandom), $urandom & 32'hFFFFF);
        end

        run_load(123456, 1'b1, 1'b0, 8);
        blink_en = 1'b1;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            check_seg("blink");
        end
        blink_en = 1'b0;
        @(negedge clk);
        check_eq("blink_off", seg, cur_disp);

        data = DATA_W'(123456); mode = 1'b1; blank_lz = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midreset_seg", seg, {SW{1'b1}});
        check_eq("midreset_busy", busy, 0);
        check_eq("midreset_ovf", overflow, 0);
        cur_disp = '1; cur_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_seg("postreset_blank");
        run_load(654321, 1'b1, 1'b0, 5);
        run_load(32'h0002A, 1'b0, 1'b1, 6);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
